// File: rtl/i2c_cmd_arbiter_if.sv
// i2c_cmd_arbiter_if
//   Bundles the requester-side handshake and the I2C_Controller-side signals
//   of i2c_cmd_arbiter.
//   slave  : arbiter view (drives grant/done/err/busy/i2c_data/i2c_go)
//   master : environment view (drives req/req_data/i2c_end/i2c_ack)
//   Signals:
//     req[2:0]       per-requester request level
//     req_data[71:0] requester k word in [24k+23:24k] = {slave_addr, reg_addr, data}
//     grant[2:0]     one-hot pulse when a word is latched
//     done[2:0]      one-hot pulse when a transfer completes
//     err            NACK / timeout flag, valid with done
//     busy           arbiter is between LOAD and the end of GAP
//     i2c_data[23:0] word to I2C_Controller
//     i2c_go         GO to I2C_Controller
//     i2c_end        END from I2C_Controller (high when idle/finished)
//     i2c_ack[2:0]   ACK from I2C_Controller, any bit set = NACK
interface i2c_cmd_arbiter_if;
  logic [2:0]  req;
  logic [71:0] req_data;
  logic [2:0]  grant;
  logic [2:0]  done;
  logic        err;
  logic        busy;
  logic [23:0] i2c_data;
  logic        i2c_go;
  logic        i2c_end;
  logic [2:0]  i2c_ack;

  modport slave (
    input  req, req_data, i2c_end, i2c_ack,
    output grant, done, err, busy, i2c_data, i2c_go
  );

  modport master (
    output req, req_data, i2c_end, i2c_ack,
    input  grant, done, err, busy, i2c_data, i2c_go
  );
endinterface

// File: rtl/i2c_cmd_arbiter.sv
// i2c_cmd_arbiter
//   Shares one I2C_Controller between three command sources (codec init,
//   volume, spare/debug). Round-robin grant, drives GO/DATA, follows END
//   through the transfer and reports per-requester done plus an error flag.
//   Runs entirely in the clk_i2c domain.
//
//   Ports:
//     clk_i2c  I2C controller work clock
//     reset_n  asynchronous active-low reset
//     bus      i2c_cmd_arbiter_if.slave (requests, status, controller link)
//
//   Parameters:
//     BUSY_TIMEOUT  cycles allowed for END to fall after GO rises
//     GAP_CYCLES    idle cycles (GO low) between transfers
//     MAX_RETRY     extra attempts after a NACK (retry build only)
//
//   Build option:
//     I2C_RETRY_EN  when defined, a NACKed transfer is re-issued with the
//                   same word up to MAX_RETRY more times; when undefined a
//                   NACK completes at once with err = 1.
//
//   state       | meaning
//   ------------+--------------------------------------------------------
//   S_IDLE      | waiting for any req; picks the next requester
//   S_LOAD      | word latched, grant pulse, timeout counter armed
//   S_WAIT_BUSY | GO high, waiting for END to fall (bounded by timeout)
//   S_WAIT_END  | GO high, waiting for END to rise, sampling ACK
//   S_FINISH    | done/err pulse, round-robin pointer advances
//   S_GAP       | GO low for GAP_CYCLES, then IDLE (or LOAD on a retry)
module i2c_cmd_arbiter #(
  parameter int BUSY_TIMEOUT = 32,
  parameter int GAP_CYCLES   = 4,
  parameter int MAX_RETRY    = 2
) (
  input logic             clk_i2c,
  input logic             reset_n,
  i2c_cmd_arbiter_if.slave bus
);

  localparam int TMAX = (BUSY_TIMEOUT > GAP_CYCLES) ? BUSY_TIMEOUT : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX) + 1;

  if (BUSY_TIMEOUT < 2 || GAP_CYCLES < 1 || MAX_RETRY < 0) begin : g_param_check
    $error("i2c_cmd_arbiter: BUSY_TIMEOUT >= 2, GAP_CYCLES >= 1, MAX_RETRY >= 0 required");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT_BUSY, S_WAIT_END, S_FINISH, S_GAP
  } state_t;

  state_t          state, state_nxt;
  logic [1:0]      rr_ptr;
  logic [1:0]      sel;
  logic [1:0]      pick;
  logic [23:0]     pick_word;
  logic [23:0]     data_q;
  logic [TW-1:0]   timer;
  logic            err_latched;
  logic            nack;
  logic            retry_ok;
  logic            retrying;

  function automatic logic [1:0] rr_next(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  assign nack = |bus.i2c_ack;

  // First requester at or after rr_ptr, wrapping 2 -> 0. Only consumed
  // when req is nonzero, so the last fallback is always a set bit.
  always_comb begin
    pick = rr_ptr;
    if (bus.req[rr_ptr]) begin
      pick = rr_ptr;
    end else if (bus.req[rr_next(rr_ptr)]) begin
      pick = rr_next(rr_ptr);
    end else begin
      pick = rr_next(rr_next(rr_ptr));
    end
  end

  always_comb begin
    case (pick)
      2'd1:    pick_word = bus.req_data[47:24];
      2'd2:    pick_word = bus.req_data[71:48];
      default: pick_word = bus.req_data[23:0];
    endcase
  end

`ifdef I2C_RETRY_EN
  localparam int RW = $clog2(MAX_RETRY + 2);
  logic [RW-1:0] retry_cnt;

  // Counts NACKed attempts of the current word; a nonzero count also
  // marks the next LOAD as a retry so no new grant is issued.
  always_ff @(posedge clk_i2c or negedge reset_n) begin
    if (!reset_n) begin
      retry_cnt <= '0;
    end else if (state == S_WAIT_END && bus.i2c_end && nack && retry_ok) begin
      retry_cnt <= retry_cnt + 1'b1;
    end else if (state == S_FINISH) begin
      retry_cnt <= '0;
    end
  end

  assign retry_ok = (retry_cnt < RW'(MAX_RETRY));
  assign retrying = (retry_cnt != '0);
`else
  assign retry_ok = 1'b0;
  assign retrying = 1'b0;
`endif

  // state register
  always_ff @(posedge clk_i2c or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (|bus.req) state_nxt = S_LOAD;
      S_LOAD:      state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (!bus.i2c_end) begin
          state_nxt = S_WAIT_END;
        end else if (timer == '0) begin
          state_nxt = S_FINISH;
        end
      end
      S_WAIT_END: begin
        if (bus.i2c_end) begin
          state_nxt = (nack && retry_ok) ? S_GAP : S_FINISH;
        end
      end
      S_FINISH:    state_nxt = S_GAP;
      S_GAP: begin
        if (timer == '0) begin
          state_nxt = retrying ? S_LOAD : S_IDLE;
        end
      end
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers: selection, latched word, shared down-counter
  // (timeout while waiting for END to fall, gap length in GAP), error flag.
  always_ff @(posedge clk_i2c or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr      <= 2'd0;
      sel         <= 2'd0;
      data_q      <= 24'd0;
      timer       <= '0;
      err_latched <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|bus.req) begin
            sel    <= pick;
            data_q <= pick_word;
          end
        end
        S_LOAD: begin
          timer       <= TW'(BUSY_TIMEOUT - 1);
          err_latched <= 1'b0;
        end
        S_WAIT_BUSY: begin
          if (bus.i2c_end) begin
            if (timer == '0) begin
              err_latched <= 1'b1;
            end else begin
              timer <= timer - 1'b1;
            end
          end
        end
        S_WAIT_END: begin
          if (bus.i2c_end) begin
            err_latched <= nack;
            if (nack && retry_ok) begin
              timer <= TW'(GAP_CYCLES - 1);
            end
          end
        end
        S_FINISH: begin
          timer  <= TW'(GAP_CYCLES - 1);
          rr_ptr <= rr_next(sel);
        end
        S_GAP: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode straight from state so reset removes GO/busy at once.
  always_comb begin
    bus.grant  = 3'b000;
    bus.done   = 3'b000;
    bus.err    = 1'b0;
    bus.i2c_go = 1'b0;
    bus.busy   = (state != S_IDLE);
    case (state)
      S_LOAD: begin
        if (!retrying) bus.grant = 3'b001 << sel;
      end
      S_WAIT_BUSY, S_WAIT_END: bus.i2c_go = 1'b1;
      S_FINISH: begin
        bus.i2c_go = 1'b1;
        bus.done   = 3'b001 << sel;
        bus.err    = err_latched;
      end
      default: ;
    endcase
  end

  assign bus.i2c_data = data_q;

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
module tb_i2c_cmd_arbiter;

`ifdef I2C_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif
  localparam int NGO_FAIL = RETRY ? 3 : 1;

  logic clk_i2c = 1'b0;
  logic reset_n;
  i2c_cmd_arbiter_if bus();

  i2c_cmd_arbiter dut (
    .clk_i2c (clk_i2c),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial forever #50 clk_i2c = ~clk_i2c;

  typedef struct {
    int          sel;
    logic [23:0] word;
    bit          err;
    int          go;
  } exp_t;

  typedef struct {
    logic [2:0]  req;
    logic [23:0] word;
    logic [2:0]  ack_first;
    logic [2:0]  ack_rest;
    bit          tmo;
    int          sel;
    bit          err;
    int          go;
  } vec_t;

  exp_t       sb[$];
  logic [2:0] ackq[$];
  int         total = 0;
  int         bad = 0;
  bit         timeout_mode = 1'b0;
  int         low_len = 10;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name, input bit expired);
    total++;
    if (expired) begin
      bad++;
      $display("FAIL %s wait bound expired", name);
    end
  endtask

  function automatic logic [2:0] oh(input int s);
    logic [2:0] one = 3'b001;
    return one << s;
  endfunction

  // I2C_Controller model: END falls on the first GO seen, stays low for
  // low_len cycles, then rises with the next queued ACK value.
  initial begin
    bit         m_prev_go = 1'b0;
    bit         m_active = 1'b0;
    int         m_cnt = 0;
    logic [2:0] m_ack = 3'b000;
    bus.i2c_end = 1'b1;
    bus.i2c_ack = 3'b000;
    forever begin
      @(negedge clk_i2c);
      if (!reset_n) begin
        bus.i2c_end = 1'b1;
        bus.i2c_ack = 3'b000;
        m_active = 1'b0;
        m_prev_go = 1'b0;
      end else begin
        if (bus.i2c_go && !m_prev_go && !timeout_mode) begin
          bus.i2c_end = 1'b0;
          bus.i2c_ack = 3'b000;
          m_cnt = low_len;
          m_active = 1'b1;
          m_ack = 3'b000;
          if (ackq.size() > 0) m_ack = ackq.pop_front();
        end else if (m_active) begin
          m_cnt--;
          if (m_cnt <= 0) begin
            bus.i2c_end = 1'b1;
            bus.i2c_ack = m_ack;
            m_active = 1'b0;
          end
        end
        m_prev_go = bus.i2c_go;
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    bit   prev_go = 1'b0;
    int   attempts = 0;
    exp_t e;
    forever begin
      @(negedge clk_i2c);
      if (!reset_n) begin
        prev_go = 1'b0;
      end else begin
        if (bus.grant != 3'b000) begin
          check("grant_done_excl", {29'd0, bus.done}, 32'd0);
          if (sb.size() == 0) check("grant_unexpected", {29'd0, bus.grant}, 32'd0);
          else check("grant_sel", {29'd0, bus.grant}, {29'd0, oh(sb[0].sel)});
          attempts = 0;
        end
        if (bus.i2c_go && !prev_go) begin
          attempts++;
          if (sb.size() > 0) check("go_data", {8'd0, bus.i2c_data}, {8'd0, sb[0].word});
        end
        if (bus.done != 3'b000) begin
          if (sb.size() == 0) begin
            check("done_unexpected", {29'd0, bus.done}, 32'd0);
          end else begin
            e = sb.pop_front();
            check("done_sel", {29'd0, bus.done}, {29'd0, oh(e.sel)});
            check("done_err", {31'd0, bus.err}, {31'd0, e.err});
            check("go_count", attempts, e.go);
          end
        end
        prev_go = bus.i2c_go;
      end
    end
  end

  task automatic set_slices(input int sel, input logic [23:0] word);
    for (int k = 0; k < 3; k++) begin
      bus.req_data[24*k +: 24] = (k == sel) ? word : (24'hDE0000 | 24'(k));
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (bus.done == 3'b000 && n < 300) begin
      @(negedge clk_i2c);
      n++;
    end
    bound_fail(name, bus.done == 3'b000);
  endtask

  task automatic wait_grant(input string name);
    int n = 0;
    while (bus.grant == 3'b000 && n < 50) begin
      @(negedge clk_i2c);
      n++;
    end
    bound_fail(name, bus.grant == 3'b000);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.busy && n < 50) begin
      @(negedge clk_i2c);
      n++;
    end
    bound_fail(name, bus.busy);
  endtask

  task automatic run_one(input vec_t v);
    set_slices(v.sel, v.word);
    ackq.delete();
    ackq.push_back(v.ack_first);
    ackq.push_back(v.ack_rest);
    ackq.push_back(v.ack_rest);
    timeout_mode = v.tmo;
    sb.push_back('{sel: v.sel, word: v.word, err: v.err, go: v.go});
    bus.req = v.req;
    wait_done("vec_done");
    bus.req = 3'b000;
    wait_idle("vec_idle");
    timeout_mode = 1'b0;
    ackq.delete();
  endtask

  vec_t vecs[7];

  initial begin
    int         n;
    logic [2:0] seen;
    int         order[4];

    // rr_ptr is 2 when the table starts (after the single-request sequence).
    vecs[0] = '{req:3'b011, word:24'h1A2B3C, ack_first:3'b000, ack_rest:3'b000, tmo:1'b0, sel:0, err:1'b0, go:1};
    vecs[1] = '{req:3'b101, word:24'h5566AA, ack_first:3'b010, ack_rest:3'b010, tmo:1'b0, sel:2, err:1'b1, go:NGO_FAIL};
    vecs[2] = '{req:3'b100, word:24'h0F0F0F, ack_first:3'b000, ack_rest:3'b000, tmo:1'b1, sel:2, err:1'b1, go:1};
    vecs[3] = '{req:3'b110, word:24'h123456, ack_first:3'b000, ack_rest:3'b000, tmo:1'b0, sel:1, err:1'b0, go:1};
    vecs[4] = '{req:3'b001, word:24'hABCDEF, ack_first:3'b100, ack_rest:3'b000, tmo:1'b0, sel:0,
                err:(RETRY ? 1'b0 : 1'b1), go:(RETRY ? 2 : 1)};
    vecs[5] = '{req:3'b111, word:24'h777777, ack_first:3'b000, ack_rest:3'b000, tmo:1'b0, sel:1, err:1'b0, go:1};
    vecs[6] = '{req:3'b010, word:24'h2468AC, ack_first:3'b001, ack_rest:3'b001, tmo:1'b0, sel:1, err:1'b1, go:NGO_FAIL};

    reset_n = 1'b0;
    bus.req = 3'b000;
    bus.req_data = 72'd0;
    repeat (3) @(negedge clk_i2c);
    check("rst_grant", {29'd0, bus.grant}, 32'd0);
    check("rst_done", {29'd0, bus.done}, 32'd0);
    check("rst_err", {31'd0, bus.err}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_go", {31'd0, bus.i2c_go}, 32'd0);
    check("rst_data", {8'd0, bus.i2c_data}, 32'd0);
    reset_n = 1'b1;

    // Single request with full timing.
    set_slices(1, 24'h340C48);
    low_len = 10;
    ackq.push_back(3'b000);
    sb.push_back('{sel: 1, word: 24'h340C48, err: 1'b0, go: 1});
    @(negedge clk_i2c);
    bus.req = 3'b010;
    @(negedge clk_i2c);
    check("h1_grant", {29'd0, bus.grant}, 32'd2);
    check("h1_go_before", {31'd0, bus.i2c_go}, 32'd0);
    @(negedge clk_i2c);
    check("h1_go", {31'd0, bus.i2c_go}, 32'd1);
    check("h1_data", {8'd0, bus.i2c_data}, 32'h340C48);
    wait_done("h1_done");
    check("h1_done_vec", {29'd0, bus.done}, 32'd2);
    check("h1_err", {31'd0, bus.err}, 32'd0);
    bus.req = 3'b000;
    n = 0;
    while (bus.busy && n < 20) begin
      @(negedge clk_i2c);
      n++;
    end
    check("h1_busy_release", n, 32'd5);
    ackq.delete();

    foreach (vecs[i]) run_one(vecs[i]);

    // Timeout timing (rr_ptr = 2 here).
    set_slices(2, 24'h00AA55);
    timeout_mode = 1'b1;
    sb.push_back('{sel: 2, word: 24'h00AA55, err: 1'b1, go: 1});
    bus.req = 3'b100;
    n = 0;
    while (!bus.i2c_go && n < 20) begin
      @(negedge clk_i2c);
      n++;
    end
    bound_fail("tmo_go_rise", !bus.i2c_go);
    n = 0;
    while (bus.done == 3'b000 && n < 100) begin
      @(negedge clk_i2c);
      n++;
    end
    check("tmo_latency", n, 32'd32);
    check("tmo_err", {31'd0, bus.err}, 32'd1);
    bus.req = 3'b000;
    @(negedge clk_i2c);
    check("tmo_go_drop", {31'd0, bus.i2c_go}, 32'd0);
    wait_idle("tmo_idle");
    timeout_mode = 1'b0;

    // Withdrawal before grant: req[0] pulsed while requester 2 is served.
    set_slices(2, 24'h313131);
    sb.push_back('{sel: 2, word: 24'h313131, err: 1'b0, go: 1});
    bus.req = 3'b100;
    wait_grant("wd1_grant");
    repeat (2) @(negedge clk_i2c);
    bus.req = 3'b101;
    @(negedge clk_i2c);
    bus.req = 3'b100;
    wait_done("wd1_done");
    bus.req = 3'b000;
    wait_idle("wd1_idle");
    seen = 3'b000;
    repeat (12) begin
      @(negedge clk_i2c);
      seen |= bus.grant;
    end
    check("wd_not_served", {29'd0, seen}, 32'd0);

    // Withdrawal after grant: transfer still completes.
    set_slices(0, 24'h424242);
    sb.push_back('{sel: 0, word: 24'h424242, err: 1'b0, go: 1});
    bus.req = 3'b001;
    wait_grant("wd2_grant");
    bus.req = 3'b000;
    wait_done("wd2_done");
    check("wd_done0", {29'd0, bus.done}, 32'd1);
    wait_idle("wd2_idle");

    // Move rr_ptr to 2, then reset in the middle of a transfer.
    run_one('{req:3'b010, word:24'h505050, ack_first:3'b000, ack_rest:3'b000, tmo:1'b0, sel:1, err:1'b0, go:1});
    set_slices(1, 24'h616161);
    sb.push_back('{sel: 1, word: 24'h616161, err: 1'b0, go: 1});
    bus.req = 3'b010;
    wait_grant("rst_mid_grant");
    n = 0;
    while (bus.i2c_end && n < 20) begin
      @(negedge clk_i2c);
      n++;
    end
    bound_fail("rst_mid_end_low", bus.i2c_end);
    @(negedge clk_i2c);
    #10;
    reset_n = 1'b0;
    #1;
    check("rst_mid_go", {31'd0, bus.i2c_go}, 32'd0);
    check("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
    sb.delete();
    bus.req = 3'b000;
    repeat (2) @(negedge clk_i2c);
    reset_n = 1'b1;
    run_one('{req:3'b110, word:24'h727272, ack_first:3'b000, ack_rest:3'b000, tmo:1'b0, sel:1, err:1'b0, go:1});

    // Contention after a fresh reset: order 0,1,2,0 with fixed gaps.
    @(negedge clk_i2c);
    reset_n = 1'b0;
    @(negedge clk_i2c);
    reset_n = 1'b1;
    low_len = 3;
    for (int k = 0; k < 3; k++) bus.req_data[24*k +: 24] = 24'hC00000 | 24'(k);
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 0;
    for (int j = 0; j < 4; j++) begin
      sb.push_back('{sel: order[j], word: 24'hC00000 | 24'(order[j]), err: 1'b0, go: 1});
    end
    bus.req = 3'b111;
    for (int j = 0; j < 4; j++) begin
      wait_done("cont_done");
      check("cont_order", {29'd0, bus.done}, {29'd0, oh(order[j])});
      if (j < 3) begin
        n = 0;
        do begin
          @(negedge clk_i2c);
          n++;
        end while (bus.grant == 3'b000 && n < 20);
        check("cont_gap", n, 32'd6);
      end else begin
        bus.req = 3'b000;
      end
    end
    wait_idle("cont_idle");
    repeat (3) @(negedge clk_i2c);
    check("sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #(100 * 20000);
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/i2c_cmd_arbiter.md
Name: i2c_cmd_arbiter

Overview:
- Shares one I2C_Controller instance between three command sources: codec init sequencer, volume control, and a spare/debug register writer.
- Each source presents a 24-bit word {slave_addr, reg_addr[6:0], data[8:0]}. The block grants one source round-robin, drives GO/DATA, and tracks END through a full transfer.
- Returns per-requester done and error status.
- Sits between the audio config logic and I2C_Controller, in the 10 kHz clk_i2c domain.

Parameters:
- BUSY_TIMEOUT, 32: max clk_i2c cycles to wait for i2c_end to fall after go rises; on expiry, the transfer is aborted with error.
- GAP_CYCLES, 4: idle cycles, with go low, between consecutive transfers.
- MAX_RETRY, 2: extra attempts after a NACK. Used only with I2C_RETRY_EN.

Ports:
- clk_i2c  input  1  I2C controller work clock (10 kHz)
- reset_n  input  1  asynchronous active-low reset
- req  input  3  per-requester request level; held until the matching done pulse
- req_data  input  72  requester k word in bits [24k+23:24k]; stable while req[k] is high
- grant  output  3  one-hot, 1-cycle pulse when requester k's word is latched
- done  output  3  one-hot, 1-cycle pulse when requester k's transfer completes
- err  output  1  valid with any done pulse: 1 = NACK or timeout
- busy  output  1  high from LOAD through end of GAP
- i2c_data  output  24  to I2C_Controller I2C_DATA
- i2c_go  output  1  to I2C_Controller GO
- i2c_end  input  1  from I2C_Controller END (high when idle or finished)
- i2c_ack  input  3  from I2C_Controller ACK; any bit 1 = NACK

Behaviour:
- Clock and reset: one clock, clk_i2c. Reset is asynchronous, active-low on reset_n. All state clears immediately when reset_n = 0.
- Reset values: grant = 0, done = 0, err = 0, busy = 0, i2c_go = 0, i2c_data = 0, state IDLE, rr_ptr = 0, retry count = 0.
- FSM states: IDLE, LOAD, WAIT_BUSY, WAIT_END, FINISH, GAP.
- IDLE:
  - If req is nonzero, select the first set bit scanning from rr_ptr upward, wrapping 2 to 0.
  - Latch i2c_data from the selected slice, pulse grant[sel], go to LOAD.
- LOAD: i2c_go <= 1, clear the timeout counter, go to WAIT_BUSY.
- WAIT_BUSY:
  - i2c_end == 0: go to WAIT_END.
  - Counter reaches BUSY_TIMEOUT-1 with i2c_end still 1: err_latched <= 1, go to FINISH.
- WAIT_END: i2c_end == 1 means the transfer is complete. Set err_latched <= |i2c_ack and go to FINISH. No timeout in this state.
- FINISH:
  - i2c_go <= 0, pulse done[sel], drive err = err_latched for that cycle.
  - rr_ptr <= sel+1 mod 3. Go to GAP.
- GAP: hold for GAP_CYCLES cycles with busy high, then go to IDLE.
- Latency: request seen in IDLE → grant in the same cycle's registered output (1 cycle) → i2c_go high 1 cycle later.
- Minimum request-to-done time is 4 cycles plus the controller transfer time.
- Simultaneous requests: strict round-robin, no starvation. The fixed order after reset is 0, 1, 2.
- Withdrawn requests:
  - req[k] dropped before grant: not served.
  - req[k] dropped after grant: the transfer still runs, and done/err still pulse.
- The word is captured at grant, so later req_data changes do not affect the transfer in progress.
- i2c_data is held constant from LOAD through FINISH.
- Only one done bit is ever high, and never in the same cycle as a grant.
- Reset mid-transfer: i2c_go drops immediately, no done pulse is issued, and arbitration restarts at requester 0.

Optional Feature:
- I2C_RETRY_EN defined:
  - A NACK detected in WAIT_END goes to GAP, then re-enters LOAD with the same latched word and the same sel, without re-arbitrating and without a new grant.
  - Up to MAX_RETRY extra attempts are made.
  - done pulses on success, or after the final failed attempt with err = 1.
  - A timeout is not retried.
- I2C_RETRY_EN undefined: a NACK completes immediately with err = 1. The retry counter is not instantiated.

Test Plan:
- Single request: req = 3'b010 with slice 1 = 24'h34_0C_48, I2C model END low 10 cycles, ACK 0 → grant = 010; i2c_data = 24'h340C48 with go high; done = 010 with err = 0; rr_ptr = 2; busy low GAP_CYCLES after done.
- Contention: req = 3'b111 held continuously → done order 0, 1, 2, 0. Each transfer separated by 4 gap cycles, and go never overlaps two grants.
- NACK without macro: model returns ACK = 3'b010 → single attempt, done with err = 1. With I2C_RETRY_EN: 3 go assertions total, one grant, one done, err = 1. With ACK = 0 on the 2nd attempt: 2 go assertions and err = 0.
- Timeout: model holds END = 1 permanently → done 32 cycles after go rises, err = 1, go deasserted, arbiter serves the next requester.
- Withdrawal: req[0] pulsed for 1 cycle while busy serving requester 2 → requester 0 never granted. Requester 0 raised then dropped after grant → done[0] still pulses.
- Async reset asserted in WAIT_END → i2c_go = 0 and busy = 0 without a clock edge. After release, with req = 3'b110, requester 1 is granted first.
